// File: rtl/bomb_controller_pkg.sv
// Shared types and seven-segment constants for the bomb countdown controller.
// Segment bus order is {dp,g,f,e,d,c,b,a}, active-low.
package bomb_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_EXPLODED = 2'd2
  } state_t;

  localparam logic [7:0] SEG_0       = 8'hC0;
  localparam logic [7:0] SEG_1       = 8'hF9;
  localparam logic [7:0] SEG_2       = 8'hA4;
  localparam logic [7:0] SEG_3       = 8'hB0;
  localparam logic [7:0] SEG_4       = 8'h99;
  localparam logic [7:0] SEG_5       = 8'h92;
  localparam logic [7:0] SEG_6       = 8'h82;
  localparam logic [7:0] SEG_7       = 8'hF8;
  localparam logic [7:0] SEG_8       = 8'h80;
  localparam logic [7:0] SEG_9       = 8'h90;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_DP_ZERO = 8'h40;

  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bomb_controller_hex_decoder.sv
// Combinational digit-to-segment decoder; non-decimal digits blank the display.
// The dp input lights the decimal point (active-low bit 7).
module hex_decoder
  import bomb_controller_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] w_code;

  always_comb begin
    w_code = seg_code(i_digit);
    o_seg  = {w_code[7] & ~i_dp, w_code[6:0]};
  end

endmodule

// File: rtl/bomb_controller.sv
// Single-digit countdown timer driving an active-low seven-segment display.
// Optional feature macro: BOMB_CONTROLLER_BLINK_EN (blinking detonation display).
module bomb_controller
  import bomb_controller_pkg::*;
#(
  parameter int START_VALUE = 9,
  parameter int TICK_CYCLES = 40
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       start_countdown,
  output logic [7:0] hex_output
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [3:0]    START_DIGIT = 4'(START_VALUE);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_CYCLES - 1);

  state_t        r_state;
  logic [3:0]    r_digit;
  logic [PW-1:0] r_presc;
  logic          r_start_prev;

  logic          w_start_evt;
  logic          w_tick;
  logic          w_blank;
  logic          w_dp;
  logic [3:0]    w_digit;
  logic [7:0]    w_seg;

  assign w_start_evt = start_countdown & ~r_start_prev;
  assign w_tick      = (r_presc == PRESC_LAST);

`ifdef BOMB_CONTROLLER_BLINK_EN
  // Blink phase: 0 shows the lit dp-zero, 1 blanks; toggles every tick.
  logic r_blink;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_blink <= 1'b0;
    end else if (r_state == ST_COUNTING && w_tick && r_digit == 4'd0) begin
      r_blink <= 1'b0;
    end else if (r_state == ST_EXPLODED && w_tick) begin
      r_blink <= ~r_blink;
    end
  end

  assign w_blank = (r_state == ST_EXPLODED) && r_blink;
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_state      <= ST_IDLE;
      r_digit      <= START_DIGIT;
      r_presc      <= '0;
      r_start_prev <= 1'b0;
    end else begin
      r_start_prev <= start_countdown;
      case (r_state)
        ST_IDLE: begin
          if (w_start_evt) begin
            r_state <= ST_COUNTING;
            r_digit <= START_DIGIT;
            r_presc <= '0;
          end
        end
        ST_COUNTING: begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (w_tick) begin
            if (r_digit != 4'd0) begin
              r_digit <= r_digit - 4'd1;
            end else begin
              r_state <= ST_EXPLODED;
            end
          end
        end
        ST_EXPLODED: begin
          if (w_start_evt) begin
            r_state <= ST_COUNTING;
            r_digit <= START_DIGIT;
            r_presc <= '0;
          end else begin
            // Prescaler keeps running so the blink phase has a time base.
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_dp    = (r_state == ST_EXPLODED);
  assign w_digit = (r_state == ST_IDLE)     ? START_DIGIT :
                   (r_state == ST_EXPLODED) ? 4'd0 : r_digit;

  hex_decoder u_hex_decoder (
    .i_digit (w_digit),
    .i_dp    (w_dp),
    .o_seg   (w_seg)
  );

  assign hex_output = w_blank ? SEG_BLANK : w_seg;

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller: directed scenarios plus random start
// pulses and resets, compared every cycle against an elapsed-time model.
module tb_bomb_controller;

  localparam int S = 9;
  localparam int T = 40;

  logic       clk;
  logic       async_nreset;
  logic       start_countdown;
  logic [7:0] hex_output;

  int total = 0;
  int bad   = 0;

  // Model: time since the last accepted start event, or inactive (idle).
  bit m_active  = 0;
  int m_elapsed = 0;
  bit m_prev    = 0;

  bomb_controller #(.START_VALUE(S), .TICK_CYCLES(T)) dut (
    .clk             (clk),
    .async_nreset    (async_nreset),
    .start_countdown (start_countdown),
    .hex_output      (hex_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] digit_code(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_hex();
    int after;
    if (!m_active) return digit_code(S);
    if (m_elapsed < (S + 1) * T) return digit_code(S - m_elapsed / T);
    after = m_elapsed - (S + 1) * T;
`ifdef BOMB_CONTROLLER_BLINK_EN
    return ((after / T) % 2 == 1) ? 8'hFF : 8'h40;
`else
    return (after >= 0) ? 8'h40 : 8'hFF;
`endif
  endfunction

  task automatic check(input string tag);
    logic [7:0] exp_v;
    exp_v = model_hex();
    total++;
    assert (hex_output === exp_v) else begin
      bad++;
      $error("FAIL %s t=%0t elapsed=%0d observed=%02h expected=%02h",
             tag, $time, m_elapsed, hex_output, exp_v);
    end
  endtask

  // One clock cycle: drive start, advance model at the edge, check on negedge.
  task automatic step(input logic s, input string tag);
    bit counting;
    start_countdown = s;
    @(posedge clk);
    counting = m_active && (m_elapsed < (S + 1) * T);
    if (m_active) m_elapsed++;
    if (s && !m_prev && !counting) begin
      m_active  = 1;
      m_elapsed = 0;
      $display("start event at t=%0t (%s)", $time, tag);
    end
    m_prev = s;
    @(negedge clk);
    check(tag);
  endtask

  task automatic run(input int n, input logic s, input string tag);
    for (int i = 0; i < n; i++) step(s, tag);
  endtask

  // Asynchronous reset mid-cycle; output must return to the idle code at once.
  task automatic do_reset(input string tag);
    #1 async_nreset = 1'b0;
    #1;
    m_active  = 0;
    m_elapsed = 0;
    m_prev    = 0;
    $display("reset at t=%0t (%s)", $time, tag);
    check({tag, "_now"});
    @(posedge clk);
    #1 async_nreset = 1'b1;
    @(negedge clk);
    check({tag, "_after"});
  endtask

  initial begin
    async_nreset    = 1'b0;
    start_countdown = 1'b0;
    #3 check("reset_hold");
    #4 async_nreset = 1'b1;
    @(negedge clk);
    check("reset_release");

    run(20, 1'b0, "idle");

    step(1'b1, "pulse");
    run(530, 1'b0, "countdown");

    run(100, 1'b1, "held");
    run(350, 1'b0, "held_tail");

    step(1'b1, "mid_pulse");
    run(149, 1'b0, "mid_count");
    do_reset("mid_reset");
    run(10, 1'b0, "post_reset_idle");
    step(1'b1, "recount");
    run(420, 1'b0, "recount_run");

    step(1'b1, "restart_exploded");
    run(60, 1'b0, "restart_run");

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset("rand_reset");
      else step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
